// File: rtl/rename_alloc_ctrl.sv
// Rename-stage allocation controller: freelist pull gating, speculation depth and mispredict recovery.
// Optional stall counters are enabled by defining RENAME_STALL_CNT_EN.
module rename_alloc_ctrl #(
  parameter int unsigned NUM_PREGS              = 64,
  parameter int unsigned MAX_PREDICT_DEPTH      = 4,
  parameter int unsigned MAX_PREDICT_DEPTH_BITS = 3,
  localparam int unsigned PW = $clog2(NUM_PREGS),
  localparam int unsigned FW = PW + 1,
  localparam int unsigned TW = MAX_PREDICT_DEPTH_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [1:0]    req_count,
  input  logic          req_branch,
  output logic          req_ready,
  input  logic [FW-1:0] fl_num_free,
  input  logic [PW-1:0] fl_preg1,
  input  logic [PW-1:0] fl_preg2,
  output logic [1:0]    fl_pull,
  output logic [TW-1:0] fl_branch_tag_1,
  output logic [TW-1:0] fl_branch_tag_2,
  output logic          fl_shootdown,
  output logic [TW-1:0] fl_shootdown_tag,
  input  logic          br_resolve_valid,
  input  logic          br_resolve_mispredict,
  input  logic [TW-1:0] br_resolve_tag,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_preg1,
  output logic [PW-1:0] alloc_preg2,
  output logic [TW-1:0] alloc_tag,
  output logic [TW-1:0] cur_tag,
  output logic          resolve_err
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [15:0]   stall_free_cnt,
  output logic [15:0]   stall_tag_cnt
`endif
);

  typedef enum logic [1:0] {StRun, StShoot, StDrain} state_e;

  localparam logic [TW-1:0] MaxTag = TW'(MAX_PREDICT_DEPTH);

  state_e        state_q, state_d;
  logic [TW-1:0] cur_tag_q, cur_tag_d;
  logic [TW-1:0] shoot_tag_q, shoot_tag_d;
  logic          err_q, err_d;
  logic          alloc_valid_q;
  logic [PW-1:0] alloc_preg1_q, alloc_preg2_q;
  logic [TW-1:0] alloc_tag_q;

  logic mispredict, correct, free_ok, tag_full, accept, tag_inc, tag_dec;

  assign mispredict = br_resolve_valid & br_resolve_mispredict;
  assign correct    = br_resolve_valid & ~br_resolve_mispredict;
  assign free_ok    = fl_num_free >= FW'(req_count);
  assign tag_full   = cur_tag_q == MaxTag;

  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready = reset & (state_q == StRun) & free_ok & ~(req_branch & tag_full) & ~mispredict;
  assign accept    = req_valid & req_ready;
  assign tag_inc   = accept & req_branch;

  assign fl_pull          = accept ? req_count : 2'd0;
  assign fl_branch_tag_1  = accept ? cur_tag_q : '0;
  assign fl_branch_tag_2  = accept ? cur_tag_q : '0;
  assign fl_shootdown     = state_q == StShoot;
  assign fl_shootdown_tag = (state_q == StShoot) ? shoot_tag_q : '0;

  assign alloc_valid = alloc_valid_q;
  assign alloc_preg1 = alloc_preg1_q;
  assign alloc_preg2 = alloc_preg2_q;
  assign alloc_tag   = alloc_tag_q;
  assign cur_tag     = cur_tag_q;
  assign resolve_err = err_q;

  always_comb begin
    state_d     = state_q;
    cur_tag_d   = cur_tag_q;
    shoot_tag_d = shoot_tag_q;
    err_d       = err_q;
    tag_dec     = 1'b0;
    case (state_q)
      StShoot: state_d = StDrain;
      StDrain: state_d = StRun;
      default: state_d = StRun;
    endcase
    if (mispredict) begin
      if (state_q == StRun) begin
        if (br_resolve_tag != '0 && br_resolve_tag <= cur_tag_q) begin
          shoot_tag_d = br_resolve_tag;
          cur_tag_d   = br_resolve_tag - 1'b1;
          state_d     = StShoot;
        end else begin
          err_d = 1'b1;
        end
      end else if (br_resolve_tag == '0) begin
        err_d = 1'b1;
      end else if (br_resolve_tag < shoot_tag_q) begin
        // An older branch mispredicted mid-recovery: restart shootdown from it.
        shoot_tag_d = br_resolve_tag;
        cur_tag_d   = br_resolve_tag - 1'b1;
        state_d     = StShoot;
      end
    end else begin
      if (correct) begin
        if (br_resolve_tag != '0 && br_resolve_tag == cur_tag_q) begin
          tag_dec = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      cur_tag_d = cur_tag_q + {{(TW-1){1'b0}}, tag_inc} - {{(TW-1){1'b0}}, tag_dec};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      cur_tag_q     <= '0;
      shoot_tag_q   <= '0;
      err_q         <= 1'b0;
      alloc_valid_q <= 1'b0;
      alloc_preg1_q <= '0;
      alloc_preg2_q <= '0;
      alloc_tag_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_tag_q     <= cur_tag_d;
      shoot_tag_q   <= shoot_tag_d;
      err_q         <= err_d;
      alloc_valid_q <= accept;
      if (accept) begin
        alloc_preg1_q <= fl_preg1;
        alloc_preg2_q <= fl_preg2;
        alloc_tag_q   <= cur_tag_q;
      end
    end
  end

`ifdef RENAME_STALL_CNT_EN
  logic [15:0] stall_free_q, stall_tag_q;
  logic        run_req;

  assign run_req        = (state_q == StRun) & req_valid;
  assign stall_free_cnt = stall_free_q;
  assign stall_tag_cnt  = stall_tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_free_q <= '0;
      stall_tag_q  <= '0;
    end else begin
      if (run_req && !free_ok && stall_free_q != 16'hffff) stall_free_q <= stall_free_q + 16'd1;
      if (run_req && req_branch && tag_full && stall_tag_q != 16'hffff) begin
        stall_tag_q <= stall_tag_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rename_alloc_ctrl.md
# rename_alloc_ctrl

Allocation controller in front of the physical-register freelist at the rename stage. It accepts rename groups of up to two destinations from decode and drives the freelist pull count and per-slot branch tags. It tracks the current speculation depth and sequences freelist shootdown and recovery on branch mispredict. It is the only block permitted to pull from or shoot down the freelist.

## Interface
Parameters:
- NUM_PREGS, 64, number of physical registers
- MAX_PREDICT_DEPTH, 4, maximum open speculation levels
- MAX_PREDICT_DEPTH_BITS, 3, branch tag width; tag 0 means non-speculative

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  decode presents a rename group
- req_count  in  2  destinations in the group, 0..2 (3 is illegal)
- req_branch  in  1  group ends with a branch; opens a new level after the group
- req_ready  out  1  group accepted when req_valid && req_ready
- fl_num_free  in  $clog2(NUM_PREGS)+1  freelist free count
- fl_preg1, fl_preg2  in  $clog2(NUM_PREGS)  freelist candidate registers
- fl_pull  out  2  registers to pull this cycle
- fl_branch_tag_1, fl_branch_tag_2  out  MAX_PREDICT_DEPTH_BITS  tag per pulled slot
- fl_shootdown  out  1  freelist shootdown strobe
- fl_shootdown_tag  out  MAX_PREDICT_DEPTH_BITS  tag being shot down
- br_resolve_valid  in  1  branch resolution strobe
- br_resolve_mispredict  in  1  resolution was a mispredict
- br_resolve_tag  in  MAX_PREDICT_DEPTH_BITS  tag of the resolved branch (1..MAX_PREDICT_DEPTH)
- alloc_valid  out  1  registered allocation result
- alloc_preg1, alloc_preg2  out  $clog2(NUM_PREGS)  allocated registers; preg2 is valid only when count is 2
- alloc_tag  out  MAX_PREDICT_DEPTH_BITS  tag the group was allocated under
- cur_tag  out  MAX_PREDICT_DEPTH_BITS  current speculation depth
- resolve_err  out  1  sticky illegal-resolution flag

## Operation
- FSM states: RUN, SHOOT, DRAIN. Reset state is RUN.
- req_ready is 1 only when all of the following hold:
  - state == RUN
  - fl_num_free >= req_count
  - not (req_branch && cur_tag == MAX_PREDICT_DEPTH)
  - no mispredict is being presented this cycle
- On accept:
  - fl_pull = req_count; otherwise fl_pull = 0.
  - fl_branch_tag_1/2 = cur_tag.
  - If req_branch, cur_tag increments at the clock edge. The group itself uses the old tag.
- req_count 0 with req_valid: accepted with no pull. The group still opens a level if req_branch is set. alloc_valid still pulses.
- Mispredict in RUN with tag t (1 ≤ t ≤ cur_tag):
  - latch t, cur_tag <= t-1, go to SHOOT.
  - A tag of 0 or a tag > cur_tag sets resolve_err and is otherwise ignored.
- SHOOT: fl_shootdown = 1 and fl_shootdown_tag = latched tag for exactly one cycle, then DRAIN.
- DRAIN: one cycle with no pulls, so the restored list is visible; then RUN.
- A mispredict during SHOOT or DRAIN with a tag smaller than the latched tag:
  - re-latch the tag, cur_tag <= tag-1, re-enter SHOOT.
  - Equal or larger tags are ignored.
- Correct resolution is legal only for tag == cur_tag (innermost level) and decrements cur_tag. Any other tag sets resolve_err and leaves state unchanged.
- resolve_err clears only on reset.

## Timing
- req_ready, fl_pull and fl_branch_tag_* are combinational in the accept cycle; the freelist samples them at the same edge.
- alloc_valid/alloc_preg*/alloc_tag are registered: they appear one cycle after accept and hold for one cycle.
- Mispredict recovery: 2 cycles (SHOOT, DRAIN) of req_ready = 0. The earliest new accept is the third cycle after the mispredict cycle.
- Mispredict and request in the same cycle: mispredict wins and the request is not accepted.
- Correct resolution and an accepted req_branch in the same cycle: net cur_tag is unchanged. The group uses the pre-decrement cur_tag.
- Reset (async, any state): state RUN, cur_tag 0, resolve_err 0, and every output 0.

## Configuration
- RENAME_STALL_CNT_EN defined: adds outputs stall_free_cnt and stall_tag_cnt, each 16 bits, saturating, reset to 0.
  - stall_free_cnt increments each RUN cycle with req_valid && fl_num_free < req_count.
  - stall_tag_cnt increments each RUN cycle with req_valid && req_branch && cur_tag == MAX_PREDICT_DEPTH.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset release, fl_num_free = 64, req_count = 2, fl_preg1/2 = 5/9 → fl_pull = 2 same cycle, tags 0; next cycle alloc_valid = 1, alloc_preg1/2 = 5/9, alloc_tag = 0.
- fl_num_free = 1, req_count = 2 → req_ready = 0, fl_pull = 0. fl_num_free → 2 → accepted that cycle.
- Four groups with req_branch → cur_tag 1,2,3,4. A fifth branch group → req_ready = 0; with RENAME_STALL_CNT_EN, stall_tag_cnt counts the stalled cycles.
- cur_tag = 3, mispredict tag 2 with a simultaneous request → request refused, next cycle fl_shootdown = 1 with tag 2, cur_tag = 1, DRAIN, accept resumes 3 cycles after the mispredict.
- During SHOOT for tag 3, mispredict tag 1 → SHOOT repeats with tag 1, cur_tag = 0.
- cur_tag = 2, correct resolve tag 1 → resolve_err = 1, cur_tag stays 2. Async reset mid-DRAIN → all outputs 0 immediately, state RUN.
